// File: rtl/weight_updater_pkg.sv
// Shared types and helpers for the SGD weight updater and its weight RAM.
package weight_updater_pkg;

   localparam int unsigned DEF_BITWIDTH = 18;
   localparam int unsigned DEF_FRAC     = 11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_CALC,
      S_WRITE,
      S_DONE
   } state_t;

   // Address width for a given depth; never narrower than one bit.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(n)) r = 32'(i + 1);
      end
      return (r == 0) ? 1 : r;
   endfunction

   // Bit offset of a lane inside a packed column word.
   function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
      return lane * width;
   endfunction

   // Clamp a wide signed value into the signed range of 'width' bits.
   function automatic logic signed [63:0] sat_to(input logic signed [63:0] x,
                                                 input int unsigned width);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (x > hi)      return hi;
      else if (x < lo) return lo;
      else             return x;
   endfunction

endpackage

// File: rtl/weight_updater_sgd_lane.sv
// One lane of W - lr*grad with saturation; optional gradient clamp under GRAD_CLIP_EN.
module sgd_lane
   import weight_updater_pkg::*;
#(
   parameter int unsigned BITWIDTH = DEF_BITWIDTH,
   parameter int unsigned FRAC     = DEF_FRAC
) (
   input  logic signed [BITWIDTH-1:0] weight,
   input  logic signed [BITWIDTH-1:0] grad,
   input  logic signed [BITWIDTH-1:0] lr,
   output logic signed [BITWIDTH-1:0] result_c
);

   localparam int unsigned PW = 2 * BITWIDTH;
   localparam int unsigned DW = 2 * BITWIDTH + 1 - FRAC;

   logic signed [BITWIDTH-1:0] grad_c;
   logic signed [PW-1:0]       prod;
   logic signed [DW-1:0]       diff;

`ifdef GRAD_CLIP_EN
   localparam logic signed [BITWIDTH-1:0] CLIP_VAL = BITWIDTH'(64'sd1 <<< (BITWIDTH - 3));
   localparam logic signed [BITWIDTH-1:0] CLIP_NEG = -CLIP_VAL;

   always_comb begin
      grad_c = grad;
      if (grad > CLIP_VAL)      grad_c = CLIP_VAL;
      else if (grad < CLIP_NEG) grad_c = CLIP_NEG;
   end
`else
   assign grad_c = grad;
`endif

   // delta = prod >>> FRAC fits in PW-FRAC bits, so DW bits hold W - delta exactly.
   assign prod     = PW'(grad_c) * PW'(lr);
   assign diff     = DW'(weight) - DW'(prod >>> FRAC);
   assign result_c = BITWIDTH'(sat_to(64'(diff), BITWIDTH));

endmodule

// File: rtl/weight_updater.sv
// Read-modify-write SGD step over every weight RAM column; GRAD_CLIP_EN clamps gradients.
module weight_updater
   import weight_updater_pkg::*;
#(
   parameter  int unsigned NROW          = 16,
   parameter  int unsigned NCOL          = 16,
   parameter  int unsigned BITWIDTH      = DEF_BITWIDTH,
   parameter  int unsigned FRAC          = DEF_FRAC,
   localparam int unsigned ADDR_BITWIDTH = clog2(NCOL),
   localparam int unsigned ROW_W         = BITWIDTH * NROW
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [BITWIDTH-1:0]      learningRate,
   input  logic [ROW_W-1:0]         gradRow,
   input  logic                     gradValid,
   output logic                     gradReady,
   output logic [ADDR_BITWIDTH-1:0] ramAddressOut,
   input  logic [ROW_W-1:0]         ramRowOut,
   output logic [ADDR_BITWIDTH-1:0] ramAddressIn,
   output logic [ROW_W-1:0]         ramRowIn,
   output logic                     ramWriteEn,
   output logic                     busy,
   output logic                     done
);

   localparam logic [ADDR_BITWIDTH-1:0] LAST_COL = ADDR_BITWIDTH'(NCOL - 1);

   state_t                     state_q, state_d;
   logic [ADDR_BITWIDTH-1:0]   col_q, col_d;
   logic [BITWIDTH-1:0]        lr_q, lr_d;
   logic [ROW_W-1:0]           grad_q, grad_d;
   logic [ROW_W-1:0]           new_row_c;

   logic                       ready_d, wen_d, busy_d, done_d;
   logic [ADDR_BITWIDTH-1:0]   aout_d, ain_d;
   logic [ROW_W-1:0]           row_d;

   for (genvar i = 0; i < NROW; i++) begin : g_lane
      sgd_lane #(
         .BITWIDTH (BITWIDTH),
         .FRAC     (FRAC)
      ) u_lane (
         .weight   (ramRowOut[lane_lsb(i, BITWIDTH) +: BITWIDTH]),
         .grad     (grad_q[lane_lsb(i, BITWIDTH) +: BITWIDTH]),
         .lr       (lr_q),
         .result_c (new_row_c[lane_lsb(i, BITWIDTH) +: BITWIDTH])
      );
   end

   // Next state plus next value of every registered output.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      lr_d    = lr_q;
      grad_d  = grad_q;
      ready_d = 1'b0;
      aout_d  = ramAddressOut;
      ain_d   = ramAddressIn;
      row_d   = ramRowIn;
      wen_d   = 1'b0;
      busy_d  = busy;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FETCH;
               col_d   = '0;
               lr_d    = learningRate;
               busy_d  = 1'b1;
               ready_d = 1'b1;
               aout_d  = '0;
            end
         end
         S_FETCH: begin
            ready_d = 1'b1;
            if (gradValid && gradReady) begin
               grad_d  = gradRow;
               ready_d = 1'b0;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            row_d   = new_row_c;
            ain_d   = col_q;
            wen_d   = 1'b1;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            if (col_q == LAST_COL) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               col_d   = col_q + ADDR_BITWIDTH'(1);
               aout_d  = col_q + ADDR_BITWIDTH'(1);
               ready_d = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         col_q         <= '0;
         lr_q          <= '0;
         grad_q        <= '0;
         gradReady     <= 1'b0;
         ramAddressOut <= '0;
         ramAddressIn  <= '0;
         ramRowIn      <= '0;
         ramWriteEn    <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         state_q       <= state_d;
         col_q         <= col_d;
         lr_q          <= lr_d;
         grad_q        <= grad_d;
         gradReady     <= ready_d;
         ramAddressOut <= aout_d;
         ramAddressIn  <= ain_d;
         ramRowIn      <= row_d;
         ramWriteEn    <= wen_d;
         busy          <= busy_d;
         done          <= done_d;
      end
   end

endmodule

// File: doc/weight_updater.md
Name: weight_updater

Overview:
- Training-path stage directly upstream of the weight RAM: read-modify-writes every stored column of the weight matrix with one SGD step, W_new = W - lr*grad.
- Reads a column through the RAM read port, takes the matching gradient column over a valid/ready handshake, computes NROW lanes in parallel, then writes the column back.
- Sits between the backprop gradient producer and the weight RAM; it is the only writer of that RAM during training.

Parameters:
- NROW, 16, lanes per column (elements packed in one RAM word)
- NCOL, 16, number of columns (RAM depth)
- BITWIDTH, 18, signed fixed-point element width
- FRAC, 11, fractional bits of weights, gradients and learning rate
- ADDR_BITWIDTH, log2(NCOL), address width (derived)
- CLIP_VAL, 2^(BITWIDTH-3), gradient clip magnitude (used only with GRAD_CLIP_EN)

Ports:
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins a full-matrix update
- learningRate  in  BITWIDTH  signed Q(FRAC); sampled on accepted start
- gradRow  in  BITWIDTH*NROW  gradient column; lane i = bits [i*BITWIDTH +: BITWIDTH]
- gradValid  in  1  gradRow valid
- gradReady  out  1  block accepts gradRow this cycle
- ramAddressOut  out  ADDR_BITWIDTH  RAM read address
- ramRowOut  in  BITWIDTH*NROW  RAM read data; valid one posedge after address is driven (RAM samples on negedge)
- ramAddressIn  out  ADDR_BITWIDTH  RAM write address
- ramRowIn  out  BITWIDTH*NROW  RAM write data
- ramWriteEn  out  1  RAM write strobe
- busy  out  1  update in progress
- done  out  1  one-cycle pulse after the last column is written

Behaviour:
- Reset (reset==0 at posedge): state IDLE; col=0; every output 0 (gradReady, ramWriteEn, busy, done, both addresses, ramRowIn). Reset mid-update aborts it. Columns already written stay updated; no write is issued for a partially processed column. No done pulse.
- States:
  - IDLE: on start go to FETCH, col=0, latch learningRate, busy=1.
  - FETCH: gradReady=1 and ramAddressOut=col. On gradValid&&gradReady, latch gradRow and go to CALC; otherwise stay with no timeout.
  - CALC: ramRowOut now valid for col. Compute all lanes and register the result into ramRowIn. ramAddressIn=col. Go to WRITE.
  - WRITE: ramWriteEn=1 for exactly one cycle.
    - If col==NCOL-1: go to DONE.
    - Else: col+1 and go to FETCH.
  - DONE: done=1 for one cycle, busy=0, go to IDLE.
- Minimum 3 cycles per column; full update takes 3*NCOL+1 cycles after start with gradValid held high.
- start is ignored unless the state is IDLE. gradReady is 0 outside FETCH.
- Per-lane arithmetic:
  - prod = grad*lr, full 2*BITWIDTH signed.
  - delta = prod >>> FRAC (arithmetic shift; truncation toward -inf).
  - diff = W - delta in BITWIDTH+1+BITWIDTH-FRAC bits.
  - Saturate diff to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1].
- Lanes are independent; saturation in one lane does not affect the others.
- col wraps only via IDLE; ramAddressOut never exceeds NCOL-1.

Optional Feature:
- Macro GRAD_CLIP_EN.
- Defined: each gradient lane is clamped to [-CLIP_VAL, CLIP_VAL] when latched in FETCH, before the multiply. Adds no cycles.
- Undefined: gradients are used unclipped and CLIP_VAL is unused.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, FETCH, CALC, WRITE, DONE)
  - default BITWIDTH and FRAC
  - lane pack/unpack helpers
  - the saturate-to-BITWIDTH function
  - the log2 function (shared with the RAM)
- One natural sub-module: sgd_lane. A combinational per-lane clip/multiply/shift/subtract/saturate unit, instantiated NROW times via generate.

Test Plan (NROW=2, NCOL=4, BITWIDTH=18, FRAC=11, bench RAM model on negedge):
- Basic step: W all 4096 (2.0), grad all 2048 (1.0), lr=1024 (0.5), start → every RAM word becomes 3072 in both lanes; done pulses at cycle 13 after start; exactly 4 ramWriteEn pulses, addresses 0,1,2,3.
- Saturation: lane0 W=131071 with grad=-65536, lr=1024 → 131071. Lane1 W=-131072 with grad=65535, lr=2048 → -131072. Neither lane wraps.
- Backpressure: gradValid low for 5 cycles at column 2 → FSM holds FETCH with ramAddressOut=2 and ramWriteEn=0; results match the basic step; done arrives 5 cycles later.
- Reset mid-update: reset=0 in CALC of column 1 → next cycle all outputs 0, no write to address 1, no done. Word 0 updated, words 1-3 unchanged. A following start completes normally.
- Start while busy: second start pulse at column 1 → ignored; exactly NCOL writes and one done.
- GRAD_CLIP_EN: grad=60000, CLIP_VAL=32768, lr=2048, W=0 → result -32768 with macro defined, -60000 without.
